sha3_block_padder: RTL and testbench
====================================

# sha3_block_padder

Sequential padding and block-assembly stage for the SHA-3 datapath. It collects 32-bit message words from the UART-side byte packer and applies SHA-3 padding through the combinational word padder `padder1`: domain byte 0x06, zero fill, and a final 0x80 bit. It presents complete rate-sized blocks to the Keccak permutation core with a full/ack handshake.

## Interface
- `RATE_WORDS`, default 34: block size in 32-bit words (34 = 1088-bit rate, SHA3-256); legal range 2..64.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `in` in 32: message word, big-endian within the word; first byte is `in[31:24]`.
- `in_ready` in 1: `in` is valid this cycle.
- `is_last` in 1: qualifies `in_ready`; this word is the final (possibly partial) word.
- `byte_num` in 2: valid bytes in the final word (0..3); meaningful only with `is_last`.
- `buffer_full` out 1: the block is complete; upstream must not drive `in_ready`.
- `out` out 32*RATE_WORDS: assembled block; first word at the MSB end.
- `out_ready` out 1: equal to `buffer_full`; block valid for the core.
- `f_ack` in 1: one-cycle pulse from the core; block consumed.

## Operation
- States:
  - ACCEPT: collecting words.
  - PAD: self-filling after the last word.
  - FULL: block held for the core.
  - DONE: final block acknowledged.
- ACCEPT, `in_ready`=1, `is_last`=0:
  - shift `out` left 32 bits and insert `in`;
  - `count`++.
- ACCEPT, `in_ready`=1, `is_last`=1:
  - insert `padder1(in, byte_num)` (0x06 placed after the valid bytes);
  - set `pad_seen`;
  - go to PAD (or FULL if this fills the block).
- PAD: insert 32'h00000000 once per cycle; ignore `in_ready`.
- Last slot: whenever the word written lands in slot `RATE_WORDS-1` and `pad_seen` is set, OR 32'h00000080 into it.
  - Example: last word 0x11223344 with `byte_num`=3 in the final slot stores 0x11223386.
- Full block: when `count` reaches `RATE_WORDS`, go to FULL.
- FULL, `f_ack`: clear `count`.
  - If `pad_seen`, go to DONE.
  - Otherwise go to ACCEPT.
  - `out` contents are not cleared.
- FULL: `in_ready` is ignored. A word driven while `buffer_full`=1 is dropped; upstream is at fault.
- DONE: all inputs ignored until `reset`.
- Padding always fits the current block, because 0x06 and 0x80 share the final word when needed. No extra block is ever generated.
- `f_ack` outside FULL has no effect.

## Timing
- Reset values: `out`=0, `buffer_full`=0, `out_ready`=0, `count`=0, `pad_seen`=0, state ACCEPT.
- One word accepted per cycle; no input backpressure other than `buffer_full`.
- `buffer_full` rises on the edge that writes slot `RATE_WORDS-1`. It is visible the next cycle together with the final `out`.
- `f_ack` sampled high in FULL: `buffer_full` falls on that edge; a new word is accepted the following cycle.
- Zero fill after `is_last` at slot k: `buffer_full` rises `RATE_WORDS-1-k` cycles after the last-word edge.
- Reset mid-operation (any state, including PAD or FULL) discards the partial block and returns to the reset values on that edge.
- Reset has priority over `f_ack` and `in_ready` in the same cycle.

## Configuration
- `PADDER_LAST_FLAG_EN`:
  - Defined: adds output `out_last` (1 bit, reset 0). It is high with `buffer_full` when the held block is the padded final block, and clears on `f_ack`.
  - Undefined: no port; the core tracks the message end itself.

## Structure
- Shared package `sha3_pkg` holds:
  - rate constants (`RATE_WORDS_256`=34, `RATE_WORDS_512`=18);
  - `PAD_FINAL_WORD`=32'h00000080;
  - the padder state encoding (ACCEPT/PAD/FULL/DONE).
- One sub-module: the existing combinational word padder `padder1`, instantiated once on `in`/`byte_num`.
- Count and state logic stay inline.

## Test plan
- Empty message (`RATE_WORDS`=34), `in_ready`=`is_last`=1, `byte_num`=0 → `buffer_full` 34 cycles later; `out[1087:1056]`=0x06000000, `out[31:0]`=0x00000080, all other words 0.
- Words 0xAABBCCDD then last 0x11223344 with `byte_num`=2 (`RATE_WORDS`=4) → `out`=0xAABBCCDD_11220600_00000000_00000080.
- Four full words with no `is_last` (`RATE_WORDS`=4) → `buffer_full`; `f_ack` → return to ACCEPT. A last word 0x11223344 with `byte_num`=3 written into slot 3 gives 0x11223386 in the second block.
- `in_ready` pulsed during FULL and DONE → `out` and `count` unchanged; after the final `f_ack`, `buffer_full` stays 0 until reset.
- `reset` asserted mid-PAD → next cycle all outputs 0; a fresh one-word message pads correctly.
- With `PADDER_LAST_FLAG_EN`: `out_last`=0 on non-final blocks, 1 on the final block, and 0 the cycle after `f_ack`.

Source files
------------

// File: rtl/sha3_pkg.sv
// Shared SHA-3 constants and the block padder state encoding.
package sha3_pkg;

   localparam int RATE_WORDS_256 = 34;
   localparam int RATE_WORDS_512 = 18;

   localparam logic [31:0] PAD_FINAL_WORD = 32'h0000_0080;

   typedef enum logic [1:0] {
      ST_ACCEPT,
      ST_PAD,
      ST_FULL,
      ST_DONE
   } pad_state_e;

endpackage

// File: rtl/padder1.sv
// Combinational word padder: keeps byte_num leading bytes, appends 0x06.
module padder1 (
   input  logic [31:0] in,
   input  logic [1:0]  byte_num,
   output logic [31:0] out
);

   always_comb begin
      out = '0;
      unique case (byte_num)
         2'd0: out = 32'h0600_0000;
         2'd1: out = {in[31:24], 24'h06_0000};
         2'd2: out = {in[31:16], 16'h0600};
         2'd3: out = {in[31:8], 8'h06};
      endcase
   end

endmodule

// File: rtl/sha3_block_padder.sv
// SHA-3 block assembly and padding stage feeding the Keccak core.
// Optional out_last flag enabled by defining PADDER_LAST_FLAG_EN.
module sha3_block_padder
   import sha3_pkg::*;
#(
   parameter int RATE_WORDS = RATE_WORDS_256
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [31:0]             in,
   input  logic                    in_ready,
   input  logic                    is_last,
   input  logic [1:0]              byte_num,
   output logic                    buffer_full,
   output logic [32*RATE_WORDS-1:0] out,
   output logic                    out_ready,
   input  logic                    f_ack
`ifdef PADDER_LAST_FLAG_EN
   ,
   output logic                    out_last
`endif
);

   localparam int OUT_W   = 32 * RATE_WORDS;
   localparam int COUNT_W = $clog2(RATE_WORDS + 1);
   localparam logic [COUNT_W-1:0] LAST_SLOT = COUNT_W'(RATE_WORDS - 1);

   pad_state_e         state_q, state_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic               pad_seen_q, pad_seen_d;
   logic [OUT_W-1:0]   out_q, out_d;

   logic [31:0] padded_word;
   logic [31:0] word;
   logic        wr;
   logic        last_slot;

   padder1 u_padder1 (
      .in       (in),
      .byte_num (byte_num),
      .out      (padded_word)
   );

   assign last_slot = (count_q == LAST_SLOT);

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      pad_seen_d = pad_seen_q;
      out_d      = out_q;
      wr         = 1'b0;
      word       = '0;

      unique case (state_q)
         ST_ACCEPT: begin
            if (in_ready) begin
               wr = 1'b1;
               if (is_last) begin
                  word       = padded_word;
                  pad_seen_d = 1'b1;
               end else begin
                  word = in;
               end
            end
         end
         ST_PAD: begin
            wr = 1'b1;
         end
         ST_FULL: begin
            if (f_ack) begin
               count_d = '0;
               state_d = pad_seen_q ? ST_DONE : ST_ACCEPT;
            end
         end
         ST_DONE: begin
         end
      endcase

      // 0x80 closes the message in whichever word lands in the final slot
      if (wr) begin
         if (last_slot && pad_seen_d) begin
            word = word | PAD_FINAL_WORD;
         end
         out_d   = {out_q[OUT_W-33:0], word};
         count_d = count_q + 1'b1;
         if (last_slot) begin
            state_d = ST_FULL;
         end else if (pad_seen_d) begin
            state_d = ST_PAD;
         end else begin
            state_d = ST_ACCEPT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_ACCEPT;
         count_q    <= '0;
         pad_seen_q <= 1'b0;
         out_q      <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         pad_seen_q <= pad_seen_d;
         out_q      <= out_d;
      end
   end

   assign out         = out_q;
   assign buffer_full = (state_q == ST_FULL);
   assign out_ready   = buffer_full;

`ifdef PADDER_LAST_FLAG_EN
   assign out_last = buffer_full & pad_seen_q;
`endif

endmodule

// File: tb/tb_sha3_block_padder.sv
// Directed bench: RATE_WORDS=34 and RATE_WORDS=4 instances side by side.
module tb_sha3_block_padder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // instance a: RATE_WORDS = 4
   logic         a_reset, a_in_ready, a_is_last, a_f_ack;
   logic [31:0]  a_in;
   logic [1:0]   a_byte_num;
   logic         a_full, a_out_ready;
   logic [127:0] a_out;
`ifdef PADDER_LAST_FLAG_EN
   logic         a_out_last;
`endif

   // instance b: RATE_WORDS = 34
   logic          b_reset, b_in_ready, b_is_last, b_f_ack;
   logic [31:0]   b_in;
   logic [1:0]    b_byte_num;
   logic          b_full, b_out_ready;
   logic [1087:0] b_out;
`ifdef PADDER_LAST_FLAG_EN
   logic          b_out_last;
`endif

   sha3_block_padder #(.RATE_WORDS(4)) u_dut_a (
      .clk         (clk),
      .reset       (a_reset),
      .in          (a_in),
      .in_ready    (a_in_ready),
      .is_last     (a_is_last),
      .byte_num    (a_byte_num),
      .buffer_full (a_full),
      .out         (a_out),
      .out_ready   (a_out_ready),
      .f_ack       (a_f_ack)
`ifdef PADDER_LAST_FLAG_EN
      ,
      .out_last    (a_out_last)
`endif
   );

   sha3_block_padder #(.RATE_WORDS(34)) u_dut_b (
      .clk         (clk),
      .reset       (b_reset),
      .in          (b_in),
      .in_ready    (b_in_ready),
      .is_last     (b_is_last),
      .byte_num    (b_byte_num),
      .buffer_full (b_full),
      .out         (b_out),
      .out_ready   (b_out_ready),
      .f_ack       (b_f_ack)
`ifdef PADDER_LAST_FLAG_EN
      ,
      .out_last    (b_out_last)
`endif
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string tag, input logic [1087:0] obs,
                      input logic [1087:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_word(input logic [31:0] w, input logic last,
                         input logic [1:0] bn);
      a_in       = w;
      a_in_ready = 1'b1;
      a_is_last  = last;
      a_byte_num = bn;
      tick();
      a_in_ready = 1'b0;
      a_is_last  = 1'b0;
   endtask

   logic [1087:0] exp_b;
   logic [127:0]  a_hold;
   int            early;

   initial begin
      a_reset = 1'b1; a_in = '0; a_in_ready = 1'b0;
      a_is_last = 1'b0; a_byte_num = '0; a_f_ack = 1'b0;
      b_reset = 1'b1; b_in = '0; b_in_ready = 1'b0;
      b_is_last = 1'b0; b_byte_num = '0; b_f_ack = 1'b0;
      tick();
      tick();
      a_reset = 1'b0;
      b_reset = 1'b0;

      chk("rst_a_full", a_full, 0);
      chk("rst_a_ready", a_out_ready, 0);
      chk("rst_a_out", a_out, 0);
      chk("rst_b_out", b_out, 0);

      // empty message on the 34-word instance
      b_in = 32'hDEAD_BEEF; b_in_ready = 1'b1;
      b_is_last = 1'b1; b_byte_num = 2'd0;
      tick();
      b_in_ready = 1'b0; b_is_last = 1'b0;
      early = 0;
      for (int i = 0; i < 32; i++) begin
         if (b_full) early++;
         tick();
      end
      chk("b_empty_not_early", early, 0);
      chk("b_empty_pre_full", b_full, 0);
      tick();
      chk("b_empty_full", b_full, 1);
      chk("b_empty_ready", b_out_ready, 1);
      exp_b = '0;
      exp_b[1087:1056] = 32'h0600_0000;
      exp_b[31:0] = 32'h0000_0080;
      chk("b_empty_out", b_out, exp_b);
      tick();
      chk("b_empty_hold", b_full, 1);

      // two-word message, partial last word
      a_word(32'hAABB_CCDD, 1'b0, 2'd0);
      a_word(32'h1122_3344, 1'b1, 2'd2);
      chk("a_pad_not_full", a_full, 0);
      a_in = 32'hFFFF_FFFF; a_in_ready = 1'b1;
      tick();
      a_in_ready = 1'b0;
      chk("a_pad_mid", a_full, 0);
      tick();
      chk("a_pad_full", a_full, 1);
      chk("a_pad_out", a_out,
          128'hAABBCCDD_11220600_00000000_00000080);
`ifdef PADDER_LAST_FLAG_EN
      chk("a_pad_last", a_out_last, 1);
`endif
      a_f_ack = 1'b1;
      tick();
      a_f_ack = 1'b0;
      chk("a_ack_drop", a_full, 0);
`ifdef PADDER_LAST_FLAG_EN
      chk("a_ack_last_clr", a_out_last, 0);
`endif
      a_hold = a_out;
      a_word(32'h1234_5678, 1'b0, 2'd0);
      a_word(32'h1234_5678, 1'b1, 2'd1);
      a_f_ack = 1'b1;
      tick();
      a_f_ack = 1'b0;
      tick();
      chk("a_done_out", a_out, a_hold);
      chk("a_done_full", a_full, 0);

      // two blocks: full block then padded block with 0x86 merge
      a_reset = 1'b1;
      tick();
      a_reset = 1'b0;
      a_word(32'h0101_0101, 1'b0, 2'd0);
      a_word(32'h0202_0202, 1'b0, 2'd0);
      a_word(32'h0303_0303, 1'b0, 2'd0);
      chk("a_blk1_not_full", a_full, 0);
      a_word(32'h0404_0404, 1'b0, 2'd0);
      chk("a_blk1_full", a_full, 1);
      chk("a_blk1_out", a_out,
          128'h01010101_02020202_03030303_04040404);
`ifdef PADDER_LAST_FLAG_EN
      chk("a_blk1_last", a_out_last, 0);
`endif
      a_word(32'hFFFF_FFFF, 1'b0, 2'd0);
      chk("a_full_drop_out", a_out,
          128'h01010101_02020202_03030303_04040404);
      chk("a_full_drop_full", a_full, 1);
      a_f_ack = 1'b1;
      tick();
      a_f_ack = 1'b0;
      chk("a_blk1_ack", a_full, 0);
      a_word(32'hA0A0_A0A0, 1'b0, 2'd0);
      a_word(32'hB0B0_B0B0, 1'b0, 2'd0);
      a_word(32'hC0C0_C0C0, 1'b0, 2'd0);
      chk("a_blk2_not_full", a_full, 0);
      a_word(32'h1122_3344, 1'b1, 2'd3);
      chk("a_blk2_full", a_full, 1);
      chk("a_blk2_out", a_out,
          128'hA0A0A0A0_B0B0B0B0_C0C0C0C0_11223386);
`ifdef PADDER_LAST_FLAG_EN
      chk("a_blk2_last", a_out_last, 1);
`endif

      // reset during PAD, with in_ready high on the reset edge
      a_reset = 1'b1;
      tick();
      a_reset = 1'b0;
      a_word(32'h5566_7788, 1'b1, 2'd1);
      tick();
      a_reset = 1'b1;
      a_in = 32'hCAFE_F00D; a_in_ready = 1'b1;
      tick();
      a_reset = 1'b0; a_in_ready = 1'b0;
      chk("a_rst_out", a_out, 0);
      chk("a_rst_full", a_full, 0);
      chk("a_rst_ready", a_out_ready, 0);
      a_word(32'h9988_7766, 1'b1, 2'd1);
      tick();
      tick();
      chk("a_fresh_not_full", a_full, 0);
      tick();
      chk("a_fresh_full", a_full, 1);
      chk("a_fresh_out", a_out,
          128'h99060000_00000000_00000000_00000080);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
